// File: rtl/note_pkg.sv
// note_pkg: shared constants and the player state type for the note expander.
//   NOTE_W        width of a note code
//   BIT_WIDTH_DEF default width of the duration (frame count) field
//   state_t       player states (IDLE, PLAY)
package note_pkg;

  localparam int NOTE_W        = 8;
  localparam int BIT_WIDTH_DEF = 16;

  // state | meaning
  // IDLE  | nothing playing; pops the buffer head when one is available
  // PLAY  | cur_note is sounding; each frame_tick emits it once
  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/note_fifo.sv
// note_fifo: synchronous FIFO holding {note, duration} events.
//   clk, reset      clock and asynchronous active-low reset
//   i_push, i_data  write strobe and payload
//   i_pop           read strobe; o_head is the current head entry
//   o_count         number of stored entries (0..DEPTH)
//   o_full, o_empty count-derived flags
// A push into a full FIFO is still accepted when a pop happens in the same
// cycle; otherwise it is ignored (the caller flags the drop).
module note_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_data,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH (a power of 2).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/note_expand.sv
// note_expand: expands buffered (note, duration) events into one note_dec
// strobe per frame_tick, duration times per event.
//   clk, reset            clock and asynchronous active-low reset
//   note_in, duration     incoming event, valid with note_ready
//   frame_tick            one strobe per frame period
//   note_out, note_dec    emitted note (held between strobes) and its strobe
//   full, empty           event buffer status
//   overflow              sticky: an event was dropped on a full buffer
module note_expand
  import note_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int DEPTH     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NOTE_W-1:0]    note_in,
  input  logic [BIT_WIDTH-1:0] duration,
  input  logic                 note_ready,
  input  logic                 frame_tick,
  output logic [NOTE_W-1:0]    note_out,
  output logic                 note_dec,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow
);

  localparam int DW = NOTE_W + BIT_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]        FULL_CNT = CW'(DEPTH);
  localparam logic [BIT_WIDTH-1:0] REM_ONE  = BIT_WIDTH'(1);

  state_t               r_state, w_state_nxt;
  logic [NOTE_W-1:0]    r_cur_note, w_cur_note_nxt;
  logic [BIT_WIDTH-1:0] r_remaining, w_remaining_nxt;
  logic [NOTE_W-1:0]    r_note_out, w_note_out_nxt;
  logic                 r_note_dec, w_note_dec_nxt;
  logic                 r_overflow;

  logic [DW-1:0]        w_head;
  logic [CW-1:0]        w_count;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_pop;
  logic                 w_drop;
  logic [NOTE_W-1:0]    w_head_note;
  logic [BIT_WIDTH-1:0] w_head_dur;
  logic                 w_head_live;

  note_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (note_ready),
    .i_data  ({note_in, duration}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_head_note = w_head[DW-1 -: NOTE_W];
  assign w_head_dur  = w_head[BIT_WIDTH-1:0];
  assign w_head_live = (w_head_dur != '0);

  // A push at capacity survives only if the player frees a slot this cycle.
  assign w_drop = note_ready && (w_count == FULL_CNT) && !w_pop;

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_note_nxt  = r_cur_note;
    w_remaining_nxt = r_remaining;
    w_note_out_nxt  = r_note_out;
    w_note_dec_nxt  = 1'b0;
    w_pop           = 1'b0;
    case (r_state)
      IDLE: begin
        // Ticks seen here are simply lost. Zero-duration heads are discarded.
        if (!w_fifo_empty) begin
          w_pop = 1'b1;
          if (w_head_live) begin
            w_cur_note_nxt  = w_head_note;
            w_remaining_nxt = w_head_dur;
            w_state_nxt     = PLAY;
          end
        end
      end
      PLAY: begin
        if (frame_tick) begin
          w_note_dec_nxt = 1'b1;
          w_note_out_nxt = r_cur_note;
          if (r_remaining == REM_ONE) begin
            // Last frame of this note: chain straight into a live head so the
            // next tick is not lost; a zero-duration head goes via IDLE.
            if (!w_fifo_empty && w_head_live) begin
              w_pop           = 1'b1;
              w_cur_note_nxt  = w_head_note;
              w_remaining_nxt = w_head_dur;
            end else begin
              w_remaining_nxt = '0;
              w_state_nxt     = IDLE;
            end
          end else begin
            w_remaining_nxt = r_remaining - REM_ONE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cur_note  <= '0;
      r_remaining <= '0;
      r_note_out  <= '0;
      r_note_dec  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_note  <= w_cur_note_nxt;
      r_remaining <= w_remaining_nxt;
      r_note_out  <= w_note_out_nxt;
      r_note_dec  <= w_note_dec_nxt;
      r_overflow  <= r_overflow | w_drop;
    end
  end

  assign note_out = r_note_out;
  assign note_dec = r_note_dec;
  assign full     = w_fifo_full;
  assign empty    = w_fifo_empty;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_note_expand.sv
module tb_note_expand;

  localparam int BW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    note_in = '0;
  logic [BW-1:0] duration = '0;
  logic          note_ready = 1'b0;
  logic          frame_tick = 1'b0;
  logic [7:0]    note_out;
  logic          note_dec;
  logic          full;
  logic          empty;
  logic          overflow;

  int         total = 0;
  int         bad = 0;
  logic [7:0] sb[$];

  note_expand #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .note_in    (note_in),
    .duration   (duration),
    .note_ready (note_ready),
    .frame_tick (frame_tick),
    .note_out   (note_out),
    .note_dec   (note_dec),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every emitted frame must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (note_dec === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_dec: got note %0h want no strobe", note_out);
      end else begin
        logic [7:0] exp_n;
        exp_n = sb.pop_front();
        chk("note_out", 32'(note_out), 32'(exp_n));
      end
    end
  end

  // All drives happen 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] n, input logic [BW-1:0] d);
    note_ready = 1'b1;
    note_in    = n;
    duration   = d;
    cyc(1);
    note_ready = 1'b0;
  endtask

  task automatic tick(input bit exp_v, input logic [7:0] n);
    frame_tick = 1'b1;
    if (exp_v) sb.push_back(n);
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
  endtask

  initial begin
    // Reset values
    cyc(2);
    chk("rst_note_out", 32'(note_out), 32'h0);
    chk("rst_note_dec", 32'(note_dec), 32'h0);
    chk("rst_empty",    32'(empty),    32'h1);
    chk("rst_full",     32'(full),     32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    reset = 1'b1;
    cyc(1);

    // (0x2A,3) with 4 spaced ticks: three strobes, the fourth tick is silent
    push(8'h2A, 16'd3);
    cyc(2);
    for (int i = 0; i < 4; i++) begin
      tick(i < 3, 8'h2A);
      cyc(4);
    end
    chk("t1_empty",   32'(empty),     32'h1);
    chk("t1_hold",    32'(note_out),  32'h2A);
    chk("t1_drained", 32'(sb.size()), 32'h0);

    // Back-to-back events on consecutive ticks
    push(8'h10, 16'd2);
    push(8'h11, 16'd1);
    push(8'h12, 16'd2);
    cyc(2);
    tick(1, 8'h10);
    tick(1, 8'h10);
    tick(1, 8'h11);
    tick(1, 8'h12);
    tick(1, 8'h12);
    tick(0, 8'h00);
    cyc(3);
    chk("t2_drained", 32'(sb.size()), 32'h0);
    chk("t2_empty",   32'(empty),     32'h1);
    chk("t2_hold",    32'(note_out),  32'h12);

    // Zero-duration event is skipped
    push(8'h05, 16'd0);
    push(8'h06, 16'd1);
    cyc(3);
    tick(1, 8'h06);
    tick(0, 8'h00);
    cyc(3);
    chk("t3_drained", 32'(sb.size()), 32'h0);
    chk("t3_empty",   32'(empty),     32'h1);

    // Overflow: first event moves into the player, next DEPTH fill the buffer,
    // the one after that is dropped.
    for (int i = 0; i <= DEPTH; i++) push(8'(8'h80 + i), 16'd1);
    chk("t4_full",      32'(full),     32'h1);
    chk("t4_no_ovf",    32'(overflow), 32'h0);
    push(8'h99, 16'd1);
    chk("t4_ovf",       32'(overflow), 32'h1);
    for (int i = 0; i <= DEPTH; i++) tick(1, 8'(8'h80 + i));
    tick(0, 8'h00);
    tick(0, 8'h00);
    cyc(3);
    chk("t4_drained",   32'(sb.size()), 32'h0);
    chk("t4_empty",     32'(empty),     32'h1);
    chk("t4_not_full",  32'(full),      32'h0);
    chk("t4_ovf_stick", 32'(overflow),  32'h1);

    // Reset in the middle of a long note with another event buffered
    do_reset();
    chk("t5_ovf_clr", 32'(overflow), 32'h0);
    push(8'h30, 16'd10);
    push(8'h31, 16'd2);
    cyc(2);
    for (int i = 0; i < 4; i++) tick(1, 8'h30);
    cyc(2);
    chk("t5_buffered", 32'(empty), 32'h0);
    reset = 1'b0;
    cyc(1);
    chk("t5_rst_note_out", 32'(note_out), 32'h0);
    chk("t5_rst_note_dec", 32'(note_dec), 32'h0);
    chk("t5_rst_empty",    32'(empty),    32'h1);
    chk("t5_rst_full",     32'(full),     32'h0);
    reset = 1'b1;
    cyc(2);
    for (int i = 0; i < 3; i++) tick(0, 8'h00);
    cyc(3);
    chk("t5_drained", 32'(sb.size()), 32'h0);
    chk("t5_silent",  32'(note_out),  32'h0);

    // Full buffer, push coincident with tick-triggered pop
    push(8'h40, 16'd1);
    cyc(2);
    for (int i = 1; i <= DEPTH; i++) push(8'(8'h40 + i), 16'd1);
    chk("t6_full", 32'(full), 32'h1);
    note_ready = 1'b1;
    note_in    = 8'h49;
    duration   = 16'd1;
    tick(1, 8'h40);
    note_ready = 1'b0;
    chk("t6_no_ovf",   32'(overflow), 32'h0);
    chk("t6_still_full", 32'(full),   32'h1);
    for (int i = 1; i <= DEPTH + 1; i++) tick(1, 8'(8'h40 + i));
    tick(0, 8'h00);
    cyc(3);
    chk("t6_drained", 32'(sb.size()), 32'h0);
    chk("t6_empty",   32'(empty),     32'h1);
    chk("t6_ovf",     32'(overflow),  32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
